// File: rtl/eqy_output_monitor.sv
// eqy_output_monitor: windowed gold/gate output comparator with mismatch count and first-failure capture
module eqy_output_monitor #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 16,
  parameter int BIT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] window_len_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] gold_i,
  input  logic [WIDTH-1:0] gate_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic             first_valid_o,
  output logic [CNT_W-1:0] first_idx_o,
  output logic [BIT_W-1:0] first_bit_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q;
  logic [CNT_W-1:0] len_q, idx_q, s1_idx_q, cnt_q, cnt_d, fidx_q;
  logic [WIDTH-1:0] s1_diff_q;
  logic [BIT_W-1:0] fbit_q, bit_d;
  logic busy_q, done_q, pass_q, fv_q, drain_q, s1_valid_q;
  logic accept, last, any_d, hit;
  assign accept = state_q == RUN && in_valid_i && len_q != '0;
  assign last = idx_q == len_q - 1'b1;
  assign any_d = |s1_diff_q;
  assign hit = s1_valid_q && any_d;
  assign cnt_d = (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // Scan from the top so the lowest set bit wins.
  always_comb begin
    bit_d = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (s1_diff_q[i]) bit_d = BIT_W'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      cnt_q      <= '0;
      fv_q       <= 1'b0;
      fidx_q     <= '0;
      fbit_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s1_idx_q   <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      drain_q    <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_diff_q <= (gold_i ^ gate_i) & ~mask_i;
        s1_idx_q  <= idx_q;
        idx_q     <= idx_q + 1'b1;
      end
      cnt_q <= cnt_d;
      if (hit && !fv_q) begin
        fv_q   <= 1'b1;
        fidx_q <= s1_idx_q;
        fbit_q <= bit_d;
      end
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (start_i) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          len_q   <= window_len_i;
          idx_q   <= '0;
          cnt_q   <= '0;
          fv_q    <= 1'b0;
          fidx_q  <= '0;
          fbit_q  <= '0;
          pass_q  <= 1'b0;
        end
        RUN: if (len_q == '0 || (accept && last)) begin
          state_q <= DRAIN;
          drain_q <= 1'b0;
        end
        DRAIN: if (drain_q) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= cnt_d == '0;
        end else drain_q <= 1'b1;
        default: ;
      endcase
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pass_o = pass_q;
  assign mismatch_cnt_o = cnt_q;
  assign first_valid_o = fv_q;
  assign first_idx_o = fidx_q;
  assign first_bit_o = fbit_q;
endmodule
